// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants and small helpers for the VGA sync generator.
package vga_sync_gen_pkg;

    // Coordinate width; both counters fit a 1024-entry range.
    localparam int COORD_W = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    // Default mode: 640x480 @ 60 Hz, 25 MHz pixel rate from a 100 MHz clock.
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_TICK_DIV  = 4;

    typedef logic [COORD_W-1:0] coord_t;

    // True when lo <= v <= hi (inclusive window decode).
    function automatic logic in_window(input coord_t v, input int lo, input int hi);
        int vi;
        vi = int'(v);
        return (vi >= lo) && (vi <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Mod-TICK_DIV divider producing the one-clock pixel strobe.
module pixel_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick_en,
    output logic p_tick
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("pixel_tick_gen: TICK_DIV must be >= 2");
        end
    endgenerate

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             p_tick_reg;

    // The edge that sees the divider at its last value is the pixel-advance edge.
    assign tick_en = (div_reg == DIV_W'(TICK_DIV - 1));

    // Next divider value: wrap on the advance edge, otherwise count up.
    always_comb begin
        div_next = div_reg + DIV_W'(1);
        if (tick_en) begin
            div_next = '0;
        end
    end

    // Divider state and registered strobe, aligned with the counter update edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg    <= '0;
            p_tick_reg <= 1'b0;
        end else begin
            div_reg    <= div_next;
            p_tick_reg <= tick_en;
        end
    end

    assign p_tick = p_tick_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing source: pixel strobe, h/v counters, sync and video_on decodes.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int TICK_DIV  = DEF_TICK_DIV
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_LO = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_HI = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int V_SYNC_LO = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_HI = V_DISPLAY + V_FRONT + V_SYNC - 1;

    generate
        if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    logic   tick_en;
    coord_t h_count_reg, h_count_next;
    coord_t v_count_reg, v_count_next;
    logic   hsync_reg, hsync_next;
    logic   vsync_reg, vsync_next;
    logic   video_on_reg, video_on_next;
    logic   frame_start_reg, frame_start_next;
    logic   h_last, v_last;

    pixel_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_en(tick_en),
        .p_tick (p_tick)
    );

    assign h_last = (h_count_reg == coord_t'(H_TOTAL - 1));
    assign v_last = (v_count_reg == coord_t'(V_TOTAL - 1));

    // Next counter values and the decodes of those next values, so the
    // registered syncs/video_on line up with the registered coordinates.
    always_comb begin
        h_count_next     = h_count_reg;
        v_count_next     = v_count_reg;
        frame_start_next = 1'b0;
        if (tick_en) begin
            if (h_last) begin
                h_count_next = '0;
                if (v_last) begin
                    v_count_next     = '0;
                    frame_start_next = 1'b1;
                end else begin
                    v_count_next = v_count_reg + coord_t'(1);
                end
            end else begin
                h_count_next = h_count_reg + coord_t'(1);
            end
        end
        hsync_next    = ~in_window(h_count_next, H_SYNC_LO, H_SYNC_HI);
        vsync_next    = ~in_window(v_count_next, V_SYNC_LO, V_SYNC_HI);
        video_on_next = (int'(h_count_next) < H_DISPLAY) && (int'(v_count_next) < V_DISPLAY);
    end

    // Counters and decoded outputs all register on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count_reg     <= '0;
            v_count_reg     <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            video_on_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            h_count_reg     <= h_count_next;
            v_count_reg     <= v_count_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            video_on_reg    <= video_on_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign pixel_x     = h_count_reg;
    assign pixel_y     = v_count_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign frame_start = frame_start_reg;

endmodule
